// File: rtl/vga_sync.sv
// vga_sync: VGA raster timing generator (pixel enable, h/v position counters, syncs, frame tick).
// Latency: pix_x/pix_y/hsync/vsync come straight from registers and are mutually aligned; video_on, p_tick, frame_tick are combinational from them.
// Backpressure: none; the block is free-running with no stall or handshake.
module vga_sync #(
  parameter int CLK_DIV  = 4,
  parameter int HD       = 640,
  parameter int HF       = 16,
  parameter int HS       = 96,
  parameter int HB       = 48,
  parameter int VD       = 480,
  parameter int VF       = 10,
  parameter int VS       = 2,
  parameter int VB       = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       frame_tick
);

  localparam int HT    = HD + HF + HS + HB;
  localparam int VT    = VD + VF + VS + VB;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST     = 10'(HT - 1);
  localparam logic [9:0] V_LAST     = 10'(VT - 1);
  localparam logic [9:0] H_VIS      = 10'(HD);
  localparam logic [9:0] V_VIS      = 10'(VD);
  localparam logic [9:0] H_VIS_LAST = 10'(HD - 1);
  localparam logic [9:0] V_VIS_LAST = 10'(VD - 1);
  localparam logic [9:0] HS_FIRST   = 10'(HD + HF);
  localparam logic [9:0] HS_LAST    = 10'(HD + HF + HS - 1);
  localparam logic [9:0] VS_FIRST   = 10'(VD + VF);
  localparam logic [9:0] VS_LAST    = 10'(VD + VF + VS - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;

  // One pixel lasts CLK_DIV clocks; the enable marks the last clock of each pixel.
  assign p_tick = (div_q == DIV_LAST);

  // Divider and raster position next-state; v only moves when h wraps.
  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (p_tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Syncs decoded from next-state counters so the registered pulses line up with pix_x/pix_y.
  always_comb begin
    hsync_d = ((h_d >= HS_FIRST) && (h_d <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    vsync_d = ((v_d >= VS_FIRST) && (v_d <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
  end

  // State registers; reset restarts the raster and the divider phase at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign pix_x      = h_q;
  assign pix_y      = v_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = (h_q < H_VIS) && (v_q < V_VIS);
  assign frame_tick = p_tick && (h_q == H_VIS_LAST) && (v_q == V_VIS_LAST);

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: default timing (CLK_DIV=4), CLK_DIV=1 with active-high syncs,
// and a shrunken raster (15x8 pixels, CLK_DIV=2) so whole frames fit in a short run.
module tb_vga_sync;

  logic clk;
  logic rst_a, rst_b, rst_s;

  logic       hs_a, vs_a, vo_a, pt_a, ft_a;
  logic [9:0] x_a, y_a;
  logic       hs_b, vs_b, vo_b, pt_b, ft_b;
  logic [9:0] x_b, y_b;
  logic       hs_s, vs_s, vo_s, pt_s, ft_s;
  logic [9:0] x_s, y_s;

  int n_checks = 0;
  int n_err    = 0;

  vga_sync dut_a (
    .clk(clk), .reset(rst_a), .hsync(hs_a), .vsync(vs_a), .video_on(vo_a),
    .p_tick(pt_a), .pix_x(x_a), .pix_y(y_a), .frame_tick(ft_a)
  );

  vga_sync #(.CLK_DIV(1), .SYNC_POL(1'b1)) dut_b (
    .clk(clk), .reset(rst_b), .hsync(hs_b), .vsync(vs_b), .video_on(vo_b),
    .p_tick(pt_b), .pix_x(x_b), .pix_y(y_b), .frame_tick(ft_b)
  );

  vga_sync #(.CLK_DIV(2), .HD(8), .HF(2), .HS(3), .HB(2),
             .VD(4), .VF(1), .VS(2), .VB(1), .SYNC_POL(1'b0)) dut_s (
    .clk(clk), .reset(rst_s), .hsync(hs_s), .vsync(vs_s), .video_on(vo_s),
    .p_tick(pt_s), .pix_x(x_s), .pix_y(y_s), .frame_tick(ft_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int n, ticks, hs_lo_ticks, hs_lo_min, hs_lo_max, vo_cnt, vs_lo_cnt, seq_err, max_x, prev_x;
    int ft_cnt, ft_first, vo_err, hs_lo_clk, vs_lo_ticks, vs_lo_min, vs_lo_max, max_y, nopt, xerr;
    logic [11:0] exp_pt;

    rst_a = 1'b1; rst_b = 1'b1; rst_s = 1'b1;
    repeat (3) @(negedge clk);

    // ---------------- reset state ----------------
    check("a_rst_hsync", hs_a, 1);
    check("a_rst_vsync", vs_a, 1);
    check("a_rst_video_on", vo_a, 1);
    check("a_rst_pix_x", x_a, 0);
    check("a_rst_pix_y", y_a, 0);
    check("a_rst_p_tick", pt_a, 0);
    check("a_rst_frame_tick", ft_a, 0);
    check("b_rst_hsync", hs_b, 0);
    check("b_rst_vsync", vs_b, 0);
    check("s_rst_hsync", hs_s, 1);

    // ---------------- A: release and one full line ----------------
    exp_pt = 12'b1000_1000_1000;   // bit n: p_tick expected n clocks after release
    rst_a = 1'b0;
    n = 0; ticks = 0; hs_lo_ticks = 0; hs_lo_min = 1023; hs_lo_max = -1;
    vo_cnt = 0; vs_lo_cnt = 0; seq_err = 0; max_x = 0; prev_x = 0;
    while (n < 4000 && y_a != 10'd1) begin
      if (n < 12) check("a_p_tick_phase", pt_a, exp_pt[n]);
      if (n == 0) check("a_video_on_after_release", vo_a, 1);
      if (n == 3) check("a_pix_x_before_first_tick", x_a, 0);
      if (n == 4) check("a_pix_x_after_first_tick", x_a, 1);
      if (pt_a) ticks++;
      if (vo_a) vo_cnt++;
      if (!vs_a) vs_lo_cnt++;
      if (!hs_a) begin
        if (pt_a) hs_lo_ticks++;
        if (int'(x_a) < hs_lo_min) hs_lo_min = int'(x_a);
        if (int'(x_a) > hs_lo_max) hs_lo_max = int'(x_a);
      end
      if (int'(x_a) != prev_x) begin
        if (int'(x_a) != prev_x + 1) seq_err++;
        prev_x = int'(x_a);
      end
      if (int'(x_a) > max_x) max_x = int'(x_a);
      @(negedge clk);
      n++;
    end
    check("a_line_clocks", n, 3200);
    check("a_wrap_pix_x", x_a, 0);
    check("a_wrap_pix_y", y_a, 1);
    check("a_line_p_ticks", ticks, 800);
    check("a_max_pix_x", max_x, 799);
    check("a_pix_x_step_errs", seq_err, 0);
    check("a_hsync_lo_ticks", hs_lo_ticks, 96);
    check("a_hsync_lo_first_x", hs_lo_min, 656);
    check("a_hsync_lo_last_x", hs_lo_max, 751);
    check("a_video_on_clocks", vo_cnt, 2560);
    check("a_vsync_lo_line0", vs_lo_cnt, 0);

    // ---------------- A: async reset mid-line ----------------
    n = 0;
    while (n < 2000 && x_a != 10'd300) begin
      @(negedge clk);
      n++;
    end
    check("a_reach_x300", x_a, 300);
    check("a_reach_y1", y_a, 1);
    #2 rst_a = 1'b1;
    #1;
    check("a_async_pix_x", x_a, 0);
    check("a_async_pix_y", y_a, 0);
    check("a_async_div", 32'(dut_a.div_q), 0);
    check("a_async_hsync", hs_a, 1);
    check("a_async_vsync", vs_a, 1);
    @(negedge clk);
    rst_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) check("a_rerun_p_tick_k2", pt_a, 0);
      if (k == 3) begin
        check("a_rerun_p_tick_k3", pt_a, 1);
        check("a_rerun_pix_x_k3", x_a, 0);
      end
      if (k == 4) check("a_rerun_pix_x_k4", x_a, 1);
      @(negedge clk);
    end

    // ---------------- B: CLK_DIV=1, active-high syncs ----------------
    rst_b = 1'b0;
    nopt = 0; xerr = 0; hs_lo_clk = 0; hs_lo_min = 1023; hs_lo_max = -1;
    for (int i = 0; i <= 800; i++) begin
      if (!pt_b) nopt++;
      if (i < 800) begin
        if (int'(x_b) != i) xerr++;
        if (hs_b) begin
          hs_lo_clk++;
          if (int'(x_b) < hs_lo_min) hs_lo_min = int'(x_b);
          if (int'(x_b) > hs_lo_max) hs_lo_max = int'(x_b);
        end
      end
      if (i == 799) check("b_pix_y_end_line", y_b, 0);
      if (i == 800) begin
        check("b_wrap_pix_x", x_b, 0);
        check("b_wrap_pix_y", y_b, 1);
      end
      @(negedge clk);
    end
    check("b_p_tick_low_clocks", nopt, 0);
    check("b_pix_x_seq_errs", xerr, 0);
    check("b_hsync_hi_clocks", hs_lo_clk, 96);
    check("b_hsync_hi_first_x", hs_lo_min, 656);
    check("b_hsync_hi_last_x", hs_lo_max, 751);

    // ---------------- S: whole frames on a 15x8 raster, CLK_DIV=2 ----------------
    // pixel p = y*15+x spans clocks 2p..2p+1 after release; frame = 240 clocks.
    rst_s = 1'b0;
    ticks = 0; ft_cnt = 0; ft_first = -1; vo_err = 0; vo_cnt = 0; hs_lo_clk = 0;
    vs_lo_cnt = 0; vs_lo_ticks = 0; vs_lo_min = 1023; vs_lo_max = -1; max_y = 0;
    hs_lo_min = 1023; hs_lo_max = -1;
    for (int i = 0; i < 500; i++) begin
      if (ft_s && i < 480) begin
        ft_cnt++;
        if (ft_first < 0) ft_first = i;
      end
      if (i == 105) begin
        check("s_ft_at_105", ft_s, 1);
        check("s_ft_pix_x", x_s, 7);
        check("s_ft_pix_y", y_s, 3);
      end
      if (i == 106) check("s_ft_one_clk", ft_s, 0);
      if (i == 345) check("s_ft_second_frame", ft_s, 1);
      if (vo_s !== ((x_s < 10'd8) && (y_s < 10'd4))) vo_err++;
      if (i < 240) begin
        if (pt_s) ticks++;
        if (vo_s) vo_cnt++;
        if (!hs_s) begin
          hs_lo_clk++;
          if (int'(x_s) < hs_lo_min) hs_lo_min = int'(x_s);
          if (int'(x_s) > hs_lo_max) hs_lo_max = int'(x_s);
        end
        if (!vs_s) begin
          vs_lo_cnt++;
          if (pt_s) vs_lo_ticks++;
          if (int'(y_s) < vs_lo_min) vs_lo_min = int'(y_s);
          if (int'(y_s) > vs_lo_max) vs_lo_max = int'(y_s);
        end
        if (int'(y_s) > max_y) max_y = int'(y_s);
      end
      if (i == 239) begin
        check("s_last_pix_x", x_s, 14);
        check("s_last_pix_y", y_s, 7);
      end
      if (i == 240) begin
        check("s_wrap_pix_x", x_s, 0);
        check("s_wrap_pix_y", y_s, 0);
      end
      @(negedge clk);
    end
    check("s_ft_count_2frames", ft_cnt, 2);
    check("s_ft_first_clock", ft_first, 105);
    check("s_video_on_errs", vo_err, 0);
    check("s_video_on_clocks", vo_cnt, 64);
    check("s_frame_p_ticks", ticks, 120);
    check("s_max_pix_y", max_y, 7);
    check("s_hsync_lo_clocks", hs_lo_clk, 48);
    check("s_hsync_lo_first_x", hs_lo_min, 10);
    check("s_hsync_lo_last_x", hs_lo_max, 12);
    check("s_vsync_lo_clocks", vs_lo_cnt, 60);
    check("s_vsync_lo_ticks", vs_lo_ticks, 30);
    check("s_vsync_lo_first_y", vs_lo_min, 5);
    check("s_vsync_lo_last_y", vs_lo_max, 6);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
